// File: rtl/avl_stream_frame_mux.sv
// N-channel Avalon-ST multiplexer that switches channels only on frame boundaries of the selected stream.
// Optional protocol checker enabled by defining STREAM_MUX_ERR_CHECK_EN; otherwise err_o is tied low.
module avl_stream_frame_mux #(
   parameter int N_CH        = 4,
   parameter int DATA_WIDTH  = 8,
   parameter int SEL_WIDTH   = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [SEL_WIDTH-1:0]       sel_i,
   input  logic [N_CH-1:0]            valid_i,
   input  logic [N_CH*DATA_WIDTH-1:0] data_i,
   input  logic [N_CH-1:0]            sop_i,
   input  logic [N_CH-1:0]            eop_i,
   output logic                       valid_o,
   output logic [DATA_WIDTH-1:0]      data_o,
   output logic                       sop_o,
   output logic                       eop_o,
   output logic [SEL_WIDTH-1:0]       active_sel_o,
   output logic [15:0]                frame_cnt_o,
   output logic                       err_o
);

   // state    | meaning
   // WAIT_SOP | between frames; selection tracks request, only a sop of sel_active is forwarded
   // IN_FRAME | forwarding the frame of sel_active; selection frozen until eop
   localparam logic [0:0] WAIT_SOP = 1'b0;
   localparam logic [0:0] IN_FRAME = 1'b1;

   logic [SEL_WIDTH-1:0]  sync_q [SYNC_STAGES];
   logic [SEL_WIDTH-1:0]  sel_sync;
   logic [SEL_WIDTH-1:0]  eff_req;
   logic [0:0]            state_q, state_d;
   logic [SEL_WIDTH-1:0]  sel_active_q, sel_active_d;
   logic                  act_valid, act_sop, act_eop;
   logic [DATA_WIDTH-1:0] act_data;
   logic                  fwd;
   logic                  valid_q, sop_q, eop_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [15:0]           frame_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= sel_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign sel_sync = sync_q[SYNC_STAGES-1];
   assign eff_req  = (32'(sel_sync) >= N_CH) ? '0 : sel_sync;

   always_comb begin
      act_valid = 1'b0;
      act_sop   = 1'b0;
      act_eop   = 1'b0;
      act_data  = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (32'(sel_active_q) == k) begin
            act_valid = valid_i[k];
            act_sop   = sop_i[k];
            act_eop   = eop_i[k];
            act_data  = data_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // A sop that opens a multi-beat frame keeps the old selection so the whole frame comes from it.
   always_comb begin
      state_d      = state_q;
      sel_active_d = sel_active_q;
      fwd          = 1'b0;
      case (state_q)
         WAIT_SOP: begin
            fwd = act_valid & act_sop;
            if (fwd && !act_eop) state_d = IN_FRAME;
            else                 sel_active_d = eff_req;
         end
         default: begin
            fwd = act_valid;
            if (fwd && act_eop) state_d = WAIT_SOP;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= WAIT_SOP;
         sel_active_q <= '0;
         valid_q      <= 1'b0;
         data_q       <= '0;
         sop_q        <= 1'b0;
         eop_q        <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         sel_active_q <= sel_active_d;
         valid_q      <= fwd;
         if (fwd) begin
            data_q <= act_data;
            sop_q  <= act_sop;
            eop_q  <= act_eop;
         end
         if (fwd && act_eop) frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

`ifdef STREAM_MUX_ERR_CHECK_EN
   logic err_d, err_q;

   always_comb begin
      err_d = 1'b0;
      if (act_valid) begin
         if (state_q == WAIT_SOP) err_d = act_eop & ~act_sop;
         else                     err_d = act_sop;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign valid_o      = valid_q;
   assign data_o       = data_q;
   assign sop_o        = sop_q;
   assign eop_o        = eop_q;
   assign active_sel_o = sel_active_q;
   assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_avl_stream_frame_mux.sv
// Scoreboard bench for avl_stream_frame_mux: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_avl_stream_frame_mux;
   localparam int N_CH = 4;
   localparam int DW   = 8;
   localparam int SW   = 4;
   localparam int SS   = 2;
`ifdef STREAM_MUX_ERR_CHECK_EN
   localparam int ERR_EN = 1;
`else
   localparam int ERR_EN = 0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic [SW-1:0]    sel_i;
   logic [N_CH-1:0]  valid_i, sop_i, eop_i;
   logic [N_CH*DW-1:0] data_i;
   logic             valid_o, sop_o, eop_o, err_o;
   logic [DW-1:0]    data_o;
   logic [SW-1:0]    active_sel_o;
   logic [15:0]      frame_cnt_o;

   avl_stream_frame_mux #(.N_CH(N_CH), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .SYNC_STAGES(SS)) dut (
      .clk(clk), .reset(reset), .sel_i(sel_i), .valid_i(valid_i), .data_i(data_i),
      .sop_i(sop_i), .eop_i(eop_i), .valid_o(valid_o), .data_o(data_o), .sop_o(sop_o),
      .eop_o(eop_o), .active_sel_o(active_sel_o), .frame_cnt_o(frame_cnt_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [9:0] exp_q [$];
   int err_seen = 0;
   int exp_err  = 0;
   int err_on_82 = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (err_o) begin
         err_seen++;
         if (valid_o && sop_o && data_o == 8'h82) err_on_82 = 1;
      end
      if (valid_o) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", {22'd0, data_o, sop_o, eop_o}, 32'hFFFF_FFFF);
         end else begin
            logic [9:0] e;
            e = exp_q.pop_front();
            chk("beat", {22'd0, data_o, sop_o, eop_o}, {22'd0, e});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      valid_i = '0;
      sop_i   = '0;
      eop_i   = '0;
   endtask

   task automatic idle(int n);
      repeat (n) tick();
   endtask

   // Channel a may be expected at the output; channel b (if >=0) never is.
   task automatic drv(int ca, logic [7:0] da, bit sa, bit ea, bit xa,
                      int cb = -1, logic [7:0] db = 8'h00, bit sb = 1'b0, bit eb = 1'b0);
      valid_i = '0; sop_i = '0; eop_i = '0;
      if (ca >= 0) begin
         valid_i[ca] = 1'b1; sop_i[ca] = sa; eop_i[ca] = ea;
         data_i[ca*DW +: DW] = da;
         if (xa) exp_q.push_back({da, sa, ea});
      end
      if (cb >= 0) begin
         valid_i[cb] = 1'b1; sop_i[cb] = sb; eop_i[cb] = eb;
         data_i[cb*DW +: DW] = db;
      end
      tick();
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
      chk({tag, "_data"},  {24'd0, data_o}, 32'd0);
      chk({tag, "_sopeop"}, {30'd0, sop_o, eop_o}, 32'd0);
      chk({tag, "_active"}, {28'd0, active_sel_o}, 32'd0);
      chk({tag, "_fcnt"},  {16'd0, frame_cnt_o}, 32'd0);
      chk({tag, "_err"},   {31'd0, err_o}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      reset = 1'b1; sel_i = '0; valid_i = '0; sop_i = '0; eop_i = '0; data_i = '0;
      idle(2);
      chk_zero("reset");
      reset = 1'b0;
      idle(1);

      // single 4-beat frame on channel 0
      drv(0, 8'h10, 1, 0, 1);
      drv(0, 8'h11, 0, 0, 1);
      drv(0, 8'h12, 0, 0, 1);
      drv(0, 8'h13, 0, 1, 1);
      chk("t1_fcnt", {16'd0, frame_cnt_o}, 32'd1);

      // switch 0->2 mid-frame; channel 2 noise while channel 0 is in flight
      drv(0, 8'h20, 1, 0, 1);
      drv(0, 8'h21, 0, 0, 1);
      sel_i = 4'd2;
      drv(0, 8'h22, 0, 0, 1);
      drv(0, 8'h23, 0, 0, 1, 2, 8'h33, 1, 0);
      drv(0, 8'h24, 0, 0, 1, 2, 8'h34, 0, 0);
      drv(0, 8'h25, 0, 0, 1, 2, 8'h35, 1, 0);
      drv(0, 8'h26, 0, 0, 1);
      chk("t2_frozen", {28'd0, active_sel_o}, 32'd0);
      drv(0, 8'h27, 0, 1, 1);
      chk("t2_fcnt", {16'd0, frame_cnt_o}, 32'd2);
      n = 0;
      while (active_sel_o != 4'd2 && n < SS + 1) begin
         idle(1);
         n++;
      end
      chk("t2_active", {28'd0, active_sel_o}, 32'd2);
      drv(2, 8'h31, 0, 0, 0);
      drv(2, 8'h40, 1, 0, 1);
      drv(2, 8'h41, 0, 0, 1);
      drv(2, 8'h42, 0, 1, 1);
      chk("t2_fcnt2", {16'd0, frame_cnt_o}, 32'd3);

      // back to 0, then select channel 1 while it is mid-frame
      sel_i = 4'd0;
      idle(4);
      chk("t3_active0", {28'd0, active_sel_o}, 32'd0);
      drv(1, 8'h50, 1, 0, 0);
      sel_i = 4'd1;
      drv(1, 8'h51, 0, 0, 0);
      drv(1, 8'h52, 0, 0, 0);
      drv(1, 8'h53, 0, 0, 0);
      drv(1, 8'h54, 0, 0, 0);
      chk("t3_active1", {28'd0, active_sel_o}, 32'd1);
      drv(1, 8'h56, 0, 1, 0);
      exp_err += ERR_EN;
      drv(1, 8'h60, 1, 0, 1);
      drv(1, 8'h61, 0, 0, 1);
      drv(1, 8'h62, 0, 1, 1);
      chk("t3_fcnt", {16'd0, frame_cnt_o}, 32'd4);

      // out-of-range request maps to channel 0; one-beat frames
      sel_i = 4'd9;
      idle(4);
      chk("t4_active", {28'd0, active_sel_o}, 32'd0);
      drv(0, 8'h70, 1, 1, 1, 1, 8'h71, 1, 1);
      chk("t4_fcnt", {16'd0, frame_cnt_o}, 32'd5);

      // missing eop: second sop forwarded, flagged when the checker is built in
      drv(0, 8'h80, 1, 0, 1);
      drv(0, 8'h81, 0, 0, 1);
      drv(0, 8'h82, 1, 0, 1);
      exp_err += ERR_EN;
      drv(0, 8'h83, 0, 1, 1);
      chk("t5_fcnt", {16'd0, frame_cnt_o}, 32'd6);
      idle(2);
      chk("t5_err_on_sop", err_on_82, ERR_EN);

      // reset mid-frame
      drv(0, 8'h90, 1, 0, 1);
      drv(0, 8'h91, 0, 0, 1);
      reset = 1'b1;
      drv(0, 8'h92, 0, 0, 0);
      reset = 1'b0;
      chk_zero("midreset");
      drv(0, 8'h93, 0, 0, 0);
      drv(0, 8'h94, 0, 1, 0);
      exp_err += ERR_EN;
      drv(0, 8'hA0, 1, 0, 1);
      drv(0, 8'hA1, 0, 1, 1);
      chk("t6_fcnt", {16'd0, frame_cnt_o}, 32'd1);

      idle(3);
      chk("queue_empty", exp_q.size(), 32'd0);
      chk("err_count", err_seen, exp_err);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
